// File: rtl/pulse_timing_cells.sv
// Pulse-timing primitives for the core-memory controller: two retriggerable
// pulse stretchers (bd, bd2) and a fixed-latency delay line (dly100ns).
module pulse_timing_cells #(
  parameter int DLY_CYCLES = 5,
  parameter int BD_CYCLES  = 4,
  parameter int BD2_CYCLES = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic bd_in,
  output logic bd_p,
  input  logic bd2_in,
  output logic bd2_p,
  input  logic dly_in,
  output logic dly_p
);

  localparam int BdW  = $clog2(BD_CYCLES + 1);
  localparam int Bd2W = $clog2(BD2_CYCLES + 1);

  localparam logic [BdW-1:0]  BdLoad  = BdW'(BD_CYCLES);
  localparam logic [Bd2W-1:0] Bd2Load = Bd2W'(BD2_CYCLES);

  logic [BdW-1:0]        bd_cnt_q, bd_cnt_d;
  logic [Bd2W-1:0]       bd2_cnt_q, bd2_cnt_d;
  logic                  bd_p_q, bd_p_d;
  logic                  bd2_p_q, bd2_p_d;
  logic [DLY_CYCLES-1:0] dly_q, dly_d;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    bd_cnt_d = bd_cnt_q;
    if (bd_in)                bd_cnt_d = BdLoad;
    else if (bd_cnt_q != '0)  bd_cnt_d = bd_cnt_q - BdW'(1);
    // Output register tracks the next count, so a retrigger never glitches low.
    bd_p_d = (bd_cnt_d != '0);

    bd2_cnt_d = bd2_cnt_q;
    if (bd2_in)               bd2_cnt_d = Bd2Load;
    else if (bd2_cnt_q != '0) bd2_cnt_d = bd2_cnt_q - Bd2W'(1);
    bd2_p_d = (bd2_cnt_d != '0);

    dly_d    = dly_q;
    dly_d[0] = dly_in;
    for (int i = 1; i < DLY_CYCLES; i++) dly_d[i] = dly_q[i-1];
  end

  // NOTE: non-blocking assignments so all flops update from pre-edge values;
  // the shift stages are reset too, otherwise pulses in flight would survive reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bd_cnt_q  <= '0;
      bd2_cnt_q <= '0;
      bd_p_q    <= 1'b0;
      bd2_p_q   <= 1'b0;
      dly_q     <= '0;
    end else begin
      bd_cnt_q  <= bd_cnt_d;
      bd2_cnt_q <= bd2_cnt_d;
      bd_p_q    <= bd_p_d;
      bd2_p_q   <= bd2_p_d;
      dly_q     <= dly_d;
    end
  end

  assign bd_p  = bd_p_q;
  assign bd2_p = bd2_p_q;
  assign dly_p = dly_q[DLY_CYCLES-1];

endmodule

// File: tb/tb_pulse_timing_cells.sv
// Directed bench for pulse_timing_cells: default-parameter instance plus an
// all-ones parameter corner instance, checked per edge against hand-built vectors.
`timescale 1ns/1ps
module tb_pulse_timing_cells;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bd_in = 1'b0, bd2_in = 1'b0, dly_in = 1'b0;
  logic bd_p, bd2_p, dly_p;
  logic c_bd_in = 1'b0, c_bd2_in = 1'b0, c_dly_in = 1'b0;
  logic c_bd_p, c_bd2_p, c_dly_p;

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  pulse_timing_cells dut (
    .clk(clk), .reset(reset),
    .bd_in(bd_in), .bd_p(bd_p),
    .bd2_in(bd2_in), .bd2_p(bd2_p),
    .dly_in(dly_in), .dly_p(dly_p)
  );

  pulse_timing_cells #(.DLY_CYCLES(1), .BD_CYCLES(1), .BD2_CYCLES(1)) dut_min (
    .clk(clk), .reset(reset),
    .bd_in(c_bd_in), .bd_p(c_bd_p),
    .bd2_in(c_bd2_in), .bd2_p(c_bd2_p),
    .dly_in(c_dly_in), .dly_p(c_dly_p)
  );

  // Bits lo..hi set; bit k stands for "value sampled at edge k".
  function automatic logic [63:0] m(input int lo, input int hi);
    logic [63:0] v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input int edge_k, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, edge_k, obs, exp);
    end
  endtask

  // Runs one scenario over edges 0..39, edge 0 being the first edge after reset release.
  task automatic run(input string name,
                     input logic [63:0] bd_pat, input logic [63:0] bd2_pat,
                     input logic [63:0] dly_pat, input logic [63:0] rst_pat,
                     input logic [63:0] e_bd, input logic [63:0] e_bd2,
                     input logic [63:0] e_dly, input logic corner);
    logic [63:0] e_c;
    e_c = corner ? m(11, 11) : '0;
    reset = 1'b0;
    bd_in = 1'b0; bd2_in = 1'b0; dly_in = 1'b0;
    c_bd_in = 1'b0; c_bd2_in = 1'b0; c_dly_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({name, "/rst bd_p"}, -1, bd_p, 1'b0);
    check({name, "/rst bd2_p"}, -1, bd2_p, 1'b0);
    check({name, "/rst dly_p"}, -1, dly_p, 1'b0);
    check({name, "/rst min"}, -1, c_bd_p | c_bd2_p | c_dly_p, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      reset = ~rst_pat[k];
      #1;
      check({name, " bd_p"}, k, bd_p, e_bd[k]);
      check({name, " bd2_p"}, k, bd2_p, e_bd2[k]);
      check({name, " dly_p"}, k, dly_p, e_dly[k]);
      check({name, " min bd_p"}, k, c_bd_p, e_c[k]);
      check({name, " min bd2_p"}, k, c_bd2_p, e_c[k]);
      check({name, " min dly_p"}, k, c_dly_p, e_c[k]);
      bd_in  = bd_pat[k];
      bd2_in = bd2_pat[k];
      dly_in = dly_pat[k];
      c_bd_in  = corner & bd_pat[k];
      c_bd2_in = corner & bd2_pat[k];
      c_dly_in = corner & dly_pat[k];
    end
    @(negedge clk);
    bd_in = 1'b0; bd2_in = 1'b0; dly_in = 1'b0;
    c_bd_in = 1'b0; c_bd2_in = 1'b0; c_dly_in = 1'b0;
  endtask

  initial begin
    // Single one-cycle pulses on every channel at edge 10, corner instance included.
    run("single", m(10, 10), m(10, 10), m(10, 10), '0,
        m(11, 14), m(11, 22), m(15, 15), 1'b1);
    // Several delay-line pulses in flight at once.
    run("pipe", '0, '0, m(10, 10) | m(12, 13), '0,
        '0, '0, m(15, 15) | m(17, 18), 1'b0);
    // Retrigger of both stretchers while active.
    run("retrig", m(10, 10) | m(12, 12), m(10, 10) | m(20, 20), '0, '0,
        m(11, 16), m(11, 32), '0, 1'b0);
    // Inputs held high for three cycles.
    run("held", m(10, 12), '0, m(10, 12), '0,
        m(11, 16), '0, m(15, 17), 1'b0);
    // Reset asserted between edges 12 and 13, released after edge 14.
    run("midrst", '0, m(10, 10), m(10, 10), m(13, 14),
        '0, m(11, 12), '0, 1'b0);
    // Inputs on the very first edge after reset release.
    run("first", m(0, 0), m(0, 0), m(0, 0), '0,
        m(1, 4), m(1, 12), m(5, 5), 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
